fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register, issues instruction-memory requests and fills the IF/ID registers.
// Optional misaligned-fetch fault is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        fetch_fault
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t            r_state,      w_state_next;
    logic              r_ifid_valid, w_ifid_valid;
    logic [31:0]       r_ifid_instr, w_ifid_instr;
    logic [31:0]       r_ifid_pc,    w_ifid_pc;
    logic [31:0]       r_ifid_pc4,   w_ifid_pc4;
    logic [31:0]       r_buf_instr,  w_buf_instr;
    logic [31:0]       r_buf_pc,     w_buf_pc;
    logic [31:0]       r_addr_q,     w_addr_q;
    logic [WAIT_W-1:0] r_wait,       w_wait;
    logic              r_fault,      w_fault;
    logic [31:0]       w_pc4;
    logic [31:0]       w_buf_pc4;
    logic              w_misaligned;

    assign w_pc4     = pc_in + 32'd4;
    assign w_buf_pc4 = r_buf_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (pc_in[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_buf_instr  <= 32'd0;
            r_buf_pc     <= 32'd0;
            r_addr_q     <= 32'd0;
            r_wait       <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ifid_valid <= w_ifid_valid;
            r_ifid_instr <= w_ifid_instr;
            r_ifid_pc    <= w_ifid_pc;
            r_ifid_pc4   <= w_ifid_pc4;
            r_buf_instr  <= w_buf_instr;
            r_buf_pc     <= w_buf_pc;
            r_addr_q     <= w_addr_q;
            r_wait       <= w_wait;
            r_fault      <= w_fault;
        end
    end

    // Next state, register updates and combinational memory/PC outputs
    always_comb begin
        w_state_next = r_state;
        w_ifid_valid = r_ifid_valid;
        w_ifid_instr = r_ifid_instr;
        w_ifid_pc    = r_ifid_pc;
        w_ifid_pc4   = r_ifid_pc4;
        w_buf_instr  = r_buf_instr;
        w_buf_pc     = r_buf_pc;
        w_addr_q     = r_addr_q;
        w_wait       = '0;
        w_fault      = r_fault;
        pc_next      = pc_in;
        imem_req     = 1'b0;
        imem_addr    = pc_in;

        case (r_state)
            IDLE: begin
                w_state_next = REQ;
                if (redirect) begin
                    pc_next      = redirect_addr;
                    w_ifid_valid = 1'b0;
                end
            end
            REQ: begin
                imem_req = !w_misaligned;
                w_addr_q = pc_in;
                if (redirect) begin
                    // An un-acked request must still complete before the new target is fetched
                    pc_next      = redirect_addr;
                    w_ifid_valid = 1'b0;
                    w_state_next = (imem_ack || w_misaligned) ? REQ : DRAIN;
                end else if (w_misaligned) begin
                    w_fault      = 1'b1;
                    w_ifid_valid = 1'b0;
                    w_state_next = FAULT;
                end else if (imem_ack) begin
                    pc_next = w_pc4;
                    if (!stall) begin
                        w_ifid_valid = 1'b1;
                        w_ifid_instr = imem_rdata;
                        w_ifid_pc    = pc_in;
                        w_ifid_pc4   = w_pc4;
                    end else begin
                        w_buf_instr  = imem_rdata;
                        w_buf_pc     = pc_in;
                        w_state_next = HOLD;
                    end
                end else begin
                    if (!stall) begin
                        w_ifid_valid = 1'b0;
                    end
                    if (r_wait == WAIT_LAST) begin
                        w_fault      = 1'b1;
                        w_ifid_valid = 1'b0;
                        w_state_next = FAULT;
                    end else begin
                        w_wait = r_wait + WAIT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next      = redirect_addr;
                    w_ifid_valid = 1'b0;
                    w_state_next = REQ;
                end else if (!stall) begin
                    w_ifid_valid = 1'b1;
                    w_ifid_instr = r_buf_instr;
                    w_ifid_pc    = r_buf_pc;
                    w_ifid_pc4   = w_buf_pc4;
                    w_state_next = REQ;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = r_addr_q;
                if (redirect) begin
                    pc_next      = redirect_addr;
                    w_ifid_valid = 1'b0;
                end
                if (imem_ack) begin
                    w_state_next = REQ;
                end else if (r_wait == WAIT_LAST) begin
                    w_fault      = 1'b1;
                    w_ifid_valid = 1'b0;
                    w_state_next = FAULT;
                end else begin
                    w_wait = r_wait + WAIT_W'(1);
                end
            end
            FAULT: begin
                if (redirect) begin
                    pc_next      = redirect_addr;
                    w_ifid_valid = 1'b0;
                    w_fault      = 1'b0;
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ifid_valid  = r_ifid_valid;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_pc4    = r_ifid_pc4;
    assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: models the external PC register and instruction memory,
// queues expected IF/ID contents on each accepted fetch and compares when they appear.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        fetch_fault;

    exp_t sb[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    fetch_unit #(.MAX_WAIT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_in        (pc_reg),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .stall        (stall),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc4     (ifid_pc4),
        .fetch_fault  (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External program counter register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= 32'd0;
        else        pc_reg <= pc_next;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Apply this cycle's inputs; memory returns the word at the presented address
    task automatic drive(input logic ack, input logic stl, input logic redir, input logic [31:0] raddr);
        imem_ack      = ack;
        stall         = stl;
        redirect      = redir;
        redirect_addr = raddr;
        #1;
        imem_rdata = word(imem_addr);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: req=%b valid=%b fault=%b want 0 0 0", imem_req, ifid_valid, fetch_fault);
        end
        n_vec++;
        if (ifid_instr !== 32'd0 || ifid_pc !== 32'd0 || ifid_pc4 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_ifid: instr=%h pc=%h pc4=%h want zeros", ifid_instr, ifid_pc, ifid_pc4);
        end
        rst_n = 1'b1;
        n_vec++;
        if (imem_req !== 1'b0 || pc_next !== 32'd0) begin
            n_err++;
            $display("FAIL idle_cycle: req=%b pc_next=%h want 0 00000000", imem_req, pc_next);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h valid=%b want 1 00000000 0", imem_req, imem_addr, ifid_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== p) begin
                n_err++;
                $display("FAIL stream_addr%0d: req=%b addr=%h want 1 %h", i, imem_req, imem_addr, p);
            end
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            n_vec++;
            if (pc_next !== p + 32'd4) begin
                n_err++;
                $display("FAIL stream_pcnext%0d: got %h want %h", i, pc_next, p + 32'd4);
            end
            sb.push_back('{instr: word(p), pc: p, pc4: p + 32'd4});
            tick();
            e = sb.pop_front();
            n_vec++;
            if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_pc4 !== e.pc4) begin
                n_err++;
                $display("FAIL stream_ifid%0d: v=%b pc=%h instr=%h pc4=%h want 1 %h %h %h",
                         i, ifid_valid, ifid_pc, ifid_instr, ifid_pc4, e.pc, e.instr, e.pc4);
            end
            p = p + 32'd4;
        end
    endtask

    task automatic test_stall_hold();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        n_vec++;
        if (pc_next !== 32'd16) begin
            n_err++;
            $display("FAIL stall_pcnext: got %h want 00000010", pc_next);
        end
        sb.push_back('{instr: word(32'd12), pc: 32'd12, pc4: 32'd16});
        tick();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'd8 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL hold%0d: v=%b pc=%h req=%b want 1 00000008 0", i, ifid_valid, ifid_pc, imem_req);
            end
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            n_vec++;
            if (pc_next !== 32'd16) begin
                n_err++;
                $display("FAIL hold_pcnext%0d: got %h want 00000010", i, pc_next);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_pc4 !== e.pc4) begin
            n_err++;
            $display("FAIL unhold: v=%b pc=%h instr=%h pc4=%h want 1 %h %h %h",
                     ifid_valid, ifid_pc, ifid_instr, ifid_pc4, e.pc, e.instr, e.pc4);
        end
    endtask

    task automatic test_redirect_drain();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_err++;
            $display("FAIL drain_pre: req=%b addr=%h want 1 00000010", imem_req, imem_addr);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h400);
        n_vec++;
        if (pc_next !== 32'h400) begin
            n_err++;
            $display("FAIL drain_pcnext: got %h want 00000400", pc_next);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || ifid_valid !== 1'b0) begin
                n_err++;
                $display("FAIL drain_hold%0d: req=%b addr=%h v=%b want 1 00000010 0", i, imem_req, imem_addr, ifid_valid);
            end
            drive(i == 1, 1'b0, 1'b0, 32'd0);
            if (i == 0) tick();
        end
        tick();
        n_vec++;
        if (ifid_valid !== 1'b0 || sb.size() != 0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            n_err++;
            $display("FAIL drain_done: v=%b q=%0d req=%b addr=%h want 0 0 1 00000400",
                     ifid_valid, sb.size(), imem_req, imem_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        sb.push_back('{instr: word(32'h400), pc: 32'h400, pc4: 32'h404});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_instr !== e.instr) begin
            n_err++;
            $display("FAIL drain_fetch: v=%b pc=%h instr=%h want 1 %h %h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_redirect_hold();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        tick();
        n_vec++;
        if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL hold_redirect: v=%b req=%b addr=%h want 0 1 00000200", ifid_valid, imem_req, imem_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        sb.push_back('{instr: word(32'h200), pc: 32'h200, pc4: 32'h204});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_instr !== e.instr) begin
            n_err++;
            $display("FAIL hold_discard: v=%b pc=%h instr=%h want 1 %h %h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            tick();
            if (i == 14) begin
                n_vec++;
                if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h204) begin
                    n_err++;
                    $display("FAIL timeout_early: fault=%b req=%b addr=%h want 0 1 00000204", fetch_fault, imem_req, imem_addr);
                end
            end
        end
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout: fault=%b req=%b v=%b want 1 0 0", fetch_fault, imem_req, ifid_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_vec++;
        if (fetch_fault !== 1'b1 || pc_next !== 32'h204) begin
            n_err++;
            $display("FAIL fault_sticky: fault=%b pc_next=%h want 1 00000204", fetch_fault, pc_next);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        n_vec++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            n_err++;
            $display("FAIL fault_exit: fault=%b req=%b addr=%h want 0 1 00000080", fetch_fault, imem_req, imem_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        sb.push_back('{instr: word(32'h80), pc: 32'h80, pc4: 32'h84});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_instr !== e.instr) begin
            n_err++;
            $display("FAIL fault_fetch: v=%b pc=%h instr=%h want 1 %h %h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_align();
        drive(1'b1, 1'b0, 1'b1, 32'h6);
        tick();
        n_vec++;
        if (ifid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ack_redirect_drop: v=%b want 0", ifid_valid);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL align_noreq: req=%b want 0", imem_req);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        n_vec++;
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL align_fault: fault=%b req=%b want 1 0", fetch_fault, imem_req);
        end
        drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
`else
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h6) begin
            n_err++;
            $display("FAIL noalign_addr: req=%b addr=%h want 1 00000006", imem_req, imem_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        sb.push_back('{instr: word(32'h6), pc: 32'h6, pc4: 32'hA});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_pc4 !== e.pc4 || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL noalign_fetch: v=%b pc=%h pc4=%h fault=%b want 1 %h %h 0",
                     ifid_valid, ifid_pc, ifid_pc4, fetch_fault, e.pc, e.pc4);
        end
        drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
`endif
        tick();
    endtask

    task automatic test_wrap();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_addr: req=%b addr=%h fault=%b want 1 fffffffc 0", imem_req, imem_addr, fetch_fault);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        n_vec++;
        if (pc_next !== 32'd0) begin
            n_err++;
            $display("FAIL wrap_pcnext: got %h want 00000000", pc_next);
        end
        sb.push_back('{instr: word(32'hFFFFFFFC), pc: 32'hFFFFFFFC, pc4: 32'd0});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (ifid_valid !== 1'b1 || ifid_pc !== e.pc || ifid_pc4 !== e.pc4 || ifid_instr !== e.instr) begin
            n_err++;
            $display("FAIL wrap_ifid: v=%b pc=%h pc4=%h instr=%h want 1 %h %h %h",
                     ifid_valid, ifid_pc, ifid_pc4, ifid_instr, e.pc, e.pc4, e.instr);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: req=%b v=%b pc=%h fault=%b want 0 0 00000000 0",
                     imem_req, ifid_valid, ifid_pc, fetch_fault);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL reset_restart: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        redirect      = 1'b0;
        redirect_addr = 32'd0;
        stall         = 1'b0;
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_hold();
        test_timeout();
        test_align();
        test_wrap();
        test_async_reset();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
